// File: rtl/if_stage_pipe_if.sv
// Fetch-stage port bundle: hazard/ID controls in,
// IF/ID register and debug counters out.
interface if_stage_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  PCWrite;
  logic                  IF_ID_RegWrite;
  logic                  Flush;
  logic                  Branch;
  logic                  Jump;
  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] Instruction_ID;
  logic [DATA_WIDTH-1:0] PC_ID;
  logic [DATA_WIDTH-1:0] PC_plus4_ID;
  logic                  Valid_ID;
  logic [CNT_WIDTH-1:0]  stall_cnt;
  logic [CNT_WIDTH-1:0]  flush_cnt;

  modport master (
    output PCWrite, IF_ID_RegWrite, Flush,
    output Branch, Jump,
    output branch_target, jump_target,
    output imem_rdata,
    input  imem_addr, Instruction_ID,
    input  PC_ID, PC_plus4_ID, Valid_ID,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  PCWrite, IF_ID_RegWrite, Flush,
    input  Branch, Jump,
    input  branch_target, jump_target,
    input  imem_rdata,
    output imem_addr, Instruction_ID,
    output PC_ID, PC_plus4_ID, Valid_ID,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/if_stage_pipe.sv
// Instruction fetch stage: PC register, next-PC
// select, IF/ID register and saturating debug counters.
module if_stage_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] NOP      = 32'h0000_0000,
  parameter int CNT_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  if_stage_pipe_if.slave bus
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jmp_al;
  logic [DATA_WIDTH-1:0] br_al;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] pc_id_q;
  logic [DATA_WIDTH-1:0] pc4_id_q;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  stall_q;
  logic [CNT_WIDTH-1:0]  flush_q;
  logic                  flush_take;

  assign pc_plus4   = pc_q + DATA_WIDTH'(4);
  assign jmp_al     = {bus.jump_target[DATA_WIDTH-1:2], 2'b00};
  assign br_al      = {bus.branch_target[DATA_WIDTH-1:2], 2'b00};
  assign flush_take = bus.IF_ID_RegWrite & bus.Flush;

  // Next PC: hold on stall, else jump > branch > sequential
  always_comb begin
    pc_d = pc_q;
    if (bus.PCWrite) begin
      priority case (1'b1)
        bus.Jump:   pc_d = jmp_al;
        bus.Branch: pc_d = br_al;
        default:    pc_d = pc_plus4;
      endcase
    end
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  // IF/ID register: hold on stall, bubble on flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q  <= NOP;
      pc_id_q  <= '0;
      pc4_id_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus.IF_ID_RegWrite) begin
      if (bus.Flush) begin
        instr_q  <= NOP;
        pc_id_q  <= '0;
        pc4_id_q <= '0;
        valid_q  <= 1'b0;
      end else begin
        instr_q  <= bus.imem_rdata;
        pc_id_q  <= pc_q;
        pc4_id_q <= pc_plus4;
        valid_q  <= 1'b1;
      end
    end
  end

  // Saturating stall / flush event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!bus.PCWrite && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (flush_take && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.Instruction_ID = instr_q;
  assign bus.PC_ID          = pc_id_q;
  assign bus.PC_plus4_ID    = pc4_id_q;
  assign bus.Valid_ID       = valid_q;
  assign bus.stall_cnt      = stall_q;
  assign bus.flush_cnt      = flush_q;

endmodule
